// File: rtl/vga_timing_gen_if.sv
// Video output bus of the VGA timing generator: sync pulses, data enable
// and blanked RGB, all registered on the pixel tick.
//   master : driven by vga_timing_gen
//   slave  : DAC pins / monitor side
interface vga_timing_gen_if #(
    parameter int COLOR_W = 6
);
    logic               h_sync;
    logic               v_sync;
    logic               de;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;

    modport master (output h_sync, v_sync, de, red, green, blue);
    modport slave  (input  h_sync, v_sync, de, red, green, blue);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and pixel output stage.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   pix_en            pixel tick enable; all state advances only when high
//   r_in/g_in/b_in    colour from video memory, valid PIPE ticks after px_h/px_v
//   px_h, px_v        active-area coordinates (combinational)
//   de_req            counters inside the active area (undelayed)
//   line_start        tick at hc==0; frame_start: tick at hc==0, vc==0
//   vid               registered, delayed sync/DE and blanked RGB
//   frame_cnt         completed-frame count
//   dhc, dvc          raw counters (debug)
module vga_timing_gen #(
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 29,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE       = 1,
    parameter int CW         = 10,
    parameter int COLOR_W    = 6,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [CW-1:0]      px_h,
    output logic [CW-1:0]      px_v,
    output logic               de_req,
    output logic               line_start,
    output logic               frame_start,
    vga_timing_gen_if.master   vid,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [CW-1:0]      dhc,
    output logic [CW-1:0]      dvc
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYN_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYN_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_BEG = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] V_ACT_BEG = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] H_ACT_END = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_SYNC + V_BP + V_ACTIVE);

    logic [CW-1:0]      hc_q, hc_d, vc_q, vc_d;
    logic [FRAME_W-1:0] fc_q, fc_d;

    // Counters: hc wraps at end of line and carries into vc; vc wrap ends a frame.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        fc_d = fc_q;
        if (pix_en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d = '0;
                    fc_d = fc_q + FRAME_W'(1);
                end else begin
                    vc_d = vc_q + CW'(1);
                end
            end else begin
                hc_d = hc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= '0;
            vc_q <= '0;
            fc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            fc_q <= fc_d;
        end
    end

    logic hs_raw, vs_raw;
    assign hs_raw      = hc_q < H_SYN_END;
    assign vs_raw      = vc_q < V_SYN_END;
    assign de_req      = (hc_q >= H_ACT_BEG) && (hc_q < H_ACT_END) &&
                         (vc_q >= V_ACT_BEG) && (vc_q < V_ACT_END);
    assign px_h        = hc_q - H_ACT_BEG;
    assign px_v        = vc_q - V_ACT_BEG;
    assign line_start  = pix_en && (hc_q == '0);
    assign frame_start = line_start && (vc_q == '0);
    assign frame_cnt   = fc_q;
    assign dhc         = hc_q;
    assign dvc         = vc_q;

    // Delay line {hs, vs, de}: aligns timing with the video-memory read latency.
    // An all-zero stage is the inactive state, so reset clears it.
    logic [2:0] raw_v, dly_out;
    assign raw_v = {hs_raw, vs_raw, de_req};

    generate
        if (PIPE == 0) begin : g_nodly
            assign dly_out = raw_v;
        end else begin : g_dly
            logic [PIPE-1:0][2:0] dly_q, dly_d;

            always_comb begin
                dly_d = dly_q;
                if (pix_en) begin
                    dly_d[0] = raw_v;
                    for (int i = 1; i < PIPE; i++) dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dly_q <= '0;
                else        dly_q <= dly_d;
            end

            assign dly_out = dly_q[PIPE-1];
        end
    endgenerate

    // Output stage: sync polarity applied here, RGB forced to 0 while blanked.
    logic               hs_o_q, hs_o_d, vs_o_q, vs_o_d, de_o_q, de_o_d;
    logic [COLOR_W-1:0] r_o_q, r_o_d, g_o_q, g_o_d, b_o_q, b_o_d;

    always_comb begin
        hs_o_d = hs_o_q;
        vs_o_d = vs_o_q;
        de_o_d = de_o_q;
        r_o_d  = r_o_q;
        g_o_d  = g_o_q;
        b_o_d  = b_o_q;
        if (pix_en) begin
            hs_o_d = dly_out[2] ? H_SYNC_POL : ~H_SYNC_POL;
            vs_o_d = dly_out[1] ? V_SYNC_POL : ~V_SYNC_POL;
            de_o_d = dly_out[0];
            r_o_d  = dly_out[0] ? r_in : '0;
            g_o_d  = dly_out[0] ? g_in : '0;
            b_o_d  = dly_out[0] ? b_in : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_o_q <= ~H_SYNC_POL;
            vs_o_q <= ~V_SYNC_POL;
            de_o_q <= 1'b0;
            r_o_q  <= '0;
            g_o_q  <= '0;
            b_o_q  <= '0;
        end else begin
            hs_o_q <= hs_o_d;
            vs_o_q <= vs_o_d;
            de_o_q <= de_o_d;
            r_o_q  <= r_o_d;
            g_o_q  <= g_o_d;
            b_o_q  <= b_o_d;
        end
    end

    assign vid.h_sync = hs_o_q;
    assign vid.v_sync = vs_o_q;
    assign vid.de     = de_o_q;
    assign vid.red    = r_o_q;
    assign vid.green  = g_o_q;
    assign vid.blue   = b_o_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 17x8 raster so whole frames fit.
// u_a: PIPE=2, active-low syncs. u_b: PIPE=0, active-high syncs, 3-bit frame count.
module tb_vga_timing_gen;
    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 3, VF = 1;
    localparam int HT = HS + HB + HA + HF;   // 17
    localparam int VT = VS + VB + VA + VF;   // 8

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] r_a = '0, g_a = '0, b_a = '0, r_b = '0, g_b = '0, b_b = '0;
    logic [9:0] px_h_a, px_v_a, dhc_a, dvc_a, px_h_b, px_v_b, dhc_b, dvc_b;
    logic       de_req_a, ls_a, fs_a, de_req_b, ls_b, fs_b;
    logic [7:0] fc_a;
    logic [2:0] fc_b;

    vga_timing_gen_if #(.COLOR_W(6)) vid_a ();
    vga_timing_gen_if #(.COLOR_W(6)) vid_b ();

    vga_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
                     .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
                     .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE(2),
                     .CW(10), .COLOR_W(6), .FRAME_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .r_in(r_a), .g_in(g_a), .b_in(b_a),
        .px_h(px_h_a), .px_v(px_v_a), .de_req(de_req_a),
        .line_start(ls_a), .frame_start(fs_a), .vid(vid_a),
        .frame_cnt(fc_a), .dhc(dhc_a), .dvc(dvc_a));

    vga_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
                     .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
                     .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE(0),
                     .CW(10), .COLOR_W(6), .FRAME_W(3)) u_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .r_in(r_b), .g_in(g_b), .b_in(b_b),
        .px_h(px_h_b), .px_v(px_v_b), .de_req(de_req_b),
        .line_start(ls_b), .frame_start(fs_b), .vid(vid_b),
        .frame_cnt(fc_b), .dhc(dhc_b), .dvc(dvc_b));

    typedef struct {
        bit hs;
        bit vs;
        bit de;
        int x;
        int y;
    } raw_t;

    typedef struct {
        int n;      // clocks after reset
        bit tog;    // pix_en alternates 1,0,1,0 when set
        int hc;
        int vc;
        int fc;
    } vec_t;

    raw_t cur, d1, d2;
    int   mh, mv, mfc;
    int   n_chk = 0, n_pass = 0;

    logic       e_hs_a, e_vs_a, e_de_a, e_hs_b, e_vs_b, e_de_b;
    logic [5:0] e_r_a, e_g_a, e_b_a, e_r_b, e_g_b, e_b_b;

    function automatic raw_t raw_of(input int h, input int v);
        raw_t r;
        r.hs = (h < HS);
        r.vs = (v < VS);
        r.de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        r.x  = h - (HS + HB);
        r.y  = v - (VS + VB);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mfc = 0;
        d1 = '{0, 0, 0, 0, 0};
        d2 = '{0, 0, 0, 0, 0};
        e_hs_a = 1'b1; e_vs_a = 1'b1; e_de_a = 1'b0;
        e_r_a = '0; e_g_a = '0; e_b_a = '0;
        e_hs_b = 1'b0; e_vs_b = 1'b0; e_de_b = 1'b0;
        e_r_b = '0; e_g_b = '0; e_b_b = '0;
    endtask

    task automatic check_outputs();
        chk("hsync_a", {31'd0, vid_a.h_sync}, {31'd0, e_hs_a});
        chk("vsync_a", {31'd0, vid_a.v_sync}, {31'd0, e_vs_a});
        chk("de_a",    {31'd0, vid_a.de},     {31'd0, e_de_a});
        chk("red_a",   {26'd0, vid_a.red},    {26'd0, e_r_a});
        chk("green_a", {26'd0, vid_a.green},  {26'd0, e_g_a});
        chk("blue_a",  {26'd0, vid_a.blue},   {26'd0, e_b_a});
        chk("fcnt_a",  {24'd0, fc_a},         32'(mfc % 256));
        chk("hsync_b", {31'd0, vid_b.h_sync}, {31'd0, e_hs_b});
        chk("vsync_b", {31'd0, vid_b.v_sync}, {31'd0, e_vs_b});
        chk("de_b",    {31'd0, vid_b.de},     {31'd0, e_de_b});
        chk("red_b",   {26'd0, vid_b.red},    {26'd0, e_r_b});
        chk("green_b", {26'd0, vid_b.green},  {26'd0, e_g_b});
        chk("blue_b",  {26'd0, vid_b.blue},   {26'd0, e_b_b});
        chk("fcnt_b",  {29'd0, fc_b},         32'(mfc % 8));
    endtask

    task automatic do_reset();
        pix_en = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_hc", {22'd0, dhc_a}, 32'd0);
        chk("rst_vc", {22'd0, dvc_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock; a tick when en=1. Memory model: u_a sees colour of the
    // coordinates from 2 ticks back, u_b of the current coordinates.
    task automatic tick(input bit en);
        pix_en = en;
        cur = raw_of(mh, mv);
        r_a = 6'(d2.x);
        g_a = ~6'(d2.x);
        b_a = 6'(d2.x) ^ 6'h2A;
        r_b = 6'(cur.x);
        g_b = 6'(cur.y);
        b_b = ~6'(cur.x);
        #1;
        chk("dhc",    {22'd0, dhc_a},    32'(mh));
        chk("dvc",    {22'd0, dvc_a},    32'(mv));
        chk("dhc_b",  {22'd0, dhc_b},    32'(mh));
        chk("de_req", {31'd0, de_req_a}, {31'd0, cur.de});
        chk("line_start",  {31'd0, ls_a}, {31'd0, (en && mh == 0)});
        chk("frame_start", {31'd0, fs_a}, {31'd0, (en && mh == 0 && mv == 0)});
        chk("frame_start_b", {31'd0, fs_b}, {31'd0, (en && mh == 0 && mv == 0)});
        if (cur.de) begin
            chk("px_h", {22'd0, px_h_a}, {22'd0, 10'(cur.x)});
            chk("px_v", {22'd0, px_v_a}, {22'd0, 10'(cur.y)});
        end
        @(posedge clk);
        #1;
        if (en) begin
            e_hs_a = ~d2.hs;
            e_vs_a = ~d2.vs;
            e_de_a = d2.de;
            e_r_a  = d2.de ? 6'(d2.x) : 6'd0;
            e_g_a  = d2.de ? ~6'(d2.x) : 6'd0;
            e_b_a  = d2.de ? (6'(d2.x) ^ 6'h2A) : 6'd0;
            e_hs_b = cur.hs;
            e_vs_b = cur.vs;
            e_de_b = cur.de;
            e_r_b  = cur.de ? 6'(cur.x) : 6'd0;
            e_g_b  = cur.de ? 6'(cur.y) : 6'd0;
            e_b_b  = cur.de ? ~6'(cur.x) : 6'd0;
            d2 = d1;
            d1 = cur;
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == VT - 1) begin
                    mv = 0;
                    mfc++;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
        check_outputs();
    endtask

    vec_t vt[9];

    initial begin
        // Hand-computed end positions on the 17x8 raster (136 ticks per frame).
        vt[0] = '{0,    1'b0, 0,  0, 0};
        vt[1] = '{1,    1'b0, 1,  0, 0};
        vt[2] = '{16,   1'b0, 16, 0, 0};
        vt[3] = '{17,   1'b0, 0,  1, 0};
        vt[4] = '{135,  1'b0, 16, 7, 0};
        vt[5] = '{136,  1'b0, 0,  0, 1};
        vt[6] = '{272,  1'b1, 0,  0, 1};   // half-rate ticks: period doubles
        vt[7] = '{273,  1'b1, 1,  0, 1};
        vt[8] = '{1088, 1'b0, 0,  0, 8};   // 8 frames: 3-bit count wraps to 0

        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int i = 0; i < vt[v].n; i++) tick(vt[v].tog ? (i % 2 == 0) : 1'b1);
            chk("vec_hc", {22'd0, dhc_a}, 32'(vt[v].hc));
            chk("vec_vc", {22'd0, dvc_a}, 32'(vt[v].vc));
            chk("vec_fc", {24'd0, fc_a},  32'(vt[v].fc));
        end
        chk("wrap_fc_b", {29'd0, fc_b}, 32'd0);

        // Async reset mid-frame while DE is high: outputs clear without a clock edge.
        do_reset();
        for (int i = 0; i < 214; i++) tick(1'b1);
        chk("pre_rst_de",    {31'd0, vid_a.de}, 32'd1);
        chk("pre_rst_green", {26'd0, vid_a.green}, 32'd63);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_hc", {22'd0, dhc_a}, 32'd0);
        chk("async_vc", {22'd0, dvc_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick(1'b1);
        chk("post_rst_hc", {22'd0, dhc_a}, 32'd3);
        chk("post_rst_vc", {22'd0, dvc_a}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator and pixel output stage. It is the successor to the fixed 640x480 counter/sync logic in the top level.
- Generates h/v counters, sync pulses, active-pixel coordinates and frame/line strobes.
- Delays sync/DE by a configurable number of ticks to match the read latency of the character/video memory, then registers blanked RGB to the DAC pins.
- Supports a pixel clock enable, so the board clock need not equal the pixel clock.

Parameters:
- H_SYNC, 96, hsync pulse length in pixels
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse length in lines
- V_BP, 29, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- H_SYNC_POL, 0, asserted level of h_sync (0 = active low)
- V_SYNC_POL, 0, asserted level of v_sync
- PIPE, 1, video-memory read latency in pixel ticks (0..7)
- CW, 10, counter/coordinate width (must hold H_TOTAL-1, V_TOTAL-1)
- COLOR_W, 6, bits per colour channel
- FRAME_W, 8, frame counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel tick enable; all state advances only when high
- r_in  in  COLOR_W  red from video memory, valid PIPE ticks after px_h/px_v
- g_in  in  COLOR_W  green, same timing as r_in
- b_in  in  COLOR_W  blue, same timing as r_in
- px_h  out  CW  active x = hc-(H_SYNC+H_BP), combinational from counters
- px_v  out  CW  active y = vc-(V_SYNC+V_BP), combinational from counters
- de_req  out  1  counters inside active area (undelayed)
- line_start  out  1  pix_en & hc==0 (combinational)
- frame_start  out  1  pix_en & hc==0 & vc==0 (combinational)
- h_sync  out  1  registered, delayed hsync
- v_sync  out  1  registered, delayed vsync
- de  out  1  registered, delayed data enable
- red  out  COLOR_W  registered, r_in when delayed DE else 0
- green  out  COLOR_W  as red
- blue  out  COLOR_W  as red
- frame_cnt  out  FRAME_W  completed-frame count
- dhc  out  CW  raw hc (debug)
- dvc  out  CW  raw vc (debug)

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Defaults give 800x521.
- Counter origin: hc==0 is the first sync pixel. Order is sync, back porch, active, front porch. Same for vc.
- On a tick (pix_en=1):
  - hc increments.
  - At H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 with hc wrap, vc wraps to 0 and frame_cnt increments, wrapping modulo 2^FRAME_W.
- pix_en=0: every register, including the delay line, holds. Combinational strobes are 0.
- Raw terms per counter state:
  - hs_raw = hc < H_SYNC
  - vs_raw = vc < V_SYNC
  - de_req = (H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE) && (V_SYNC+V_BP <= vc < V_SYNC+V_BP+V_ACTIVE)
- px_h/px_v are modulo 2^CW subtractions. Their value is don't-care outside de_req.
- Delay line: hs_raw, vs_raw and de_req pass through a PIPE-stage shift register advancing on ticks. PIPE=0 means no stages.
- Output stage, registered on a tick:
  - h_sync = hs_d ? H_SYNC_POL : ~H_SYNC_POL; v_sync likewise.
  - de = de_d.
  - red/green/blue = de_d ? *_in : 0.
- Total latency: outputs reflect the counter state from PIPE+1 ticks earlier. r_in sampled at a tick belongs to coordinates presented PIPE ticks earlier.
- Reset (async, any time, including mid-line):
  - hc=vc=0, frame_cnt=0, delay stages cleared (inactive).
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL, de=0, RGB=0.
  - First tick after release processes hc=0, vc=0.
- No runtime reconfiguration. Parameters are elaboration-time only.

Test Plan:
- Reset then pix_en=1 for one line with defaults and PIPE=1 -> h_sync low for output ticks 2..97 (hc 0..95 delayed 2); frame_start and line_start high only on tick 1; dhc wraps 799->0 and dvc becomes 1.
- Full frame at defaults -> v_sync low exactly 2x800 ticks per frame; de high 640 ticks on each of 480 lines (307200 total); frame_cnt 0->1 after 416800 ticks; a second frame gives 2.
- Drive r_in=px_h[5:0] delayed PIPE ticks in the bench (model memory), PIPE=2 -> on the first de tick of each line red=0, incrementing to 63 and then wrapping; red/green/blue are 0 whenever de=0.
- pix_en toggling 1,0,1,0 -> identical output sequence per tick as the continuous case; outputs never change on clocks with pix_en=0; wall-clock frame period doubles.
- H_SYNC_POL=1, V_SYNC_POL=1 -> h_sync high for 96 ticks per line and idle low; v_sync high during lines 0..1; reset value low for both.
- Assert rst_n at hc=400, vc=100 mid-frame -> outputs go to reset values immediately, without waiting for a clock edge; after release, dhc/dvc restart at 0/0 and frame_cnt=0.
